// File: rtl/lfsr_pkg.sv
// Shared types and the generic single-step LFSR function for lfsr_gen.
// Optional all-zero recovery is enabled with LFSR_LOCKUP_RECOVER_EN.
package lfsr_pkg;

   typedef enum logic {LFSR_FIB, LFSR_GAL} lfsr_mode_e;

   localparam int unsigned LFSR_MAX_W = 64;

   typedef logic [LFSR_MAX_W-1:0] lfsr_vec_t;

   // Result is {emitted bit, next state}; bits at and above w stay zero.
   function automatic logic [LFSR_MAX_W:0] lfsr_next(
      input lfsr_vec_t   state,
      input lfsr_vec_t   taps,
      input lfsr_mode_e  mode,
      input int unsigned w
   );
      lfsr_vec_t mask;
      lfsr_vec_t nxt;
      logic      b;
      logic      m;
      mask = (w >= LFSR_MAX_W) ? '1
           : ((lfsr_vec_t'(1) << w) - lfsr_vec_t'(1));
      m    = |(state & (lfsr_vec_t'(1) << (w - 1)));
      unique case (mode)
         LFSR_FIB: begin
            b   = ^(state & taps & mask);
            nxt = ((state << 1) | lfsr_vec_t'(b)) & mask;
         end
         LFSR_GAL: begin
            b   = m;
            nxt = (((state << 1) | lfsr_vec_t'(m))
                  ^ ({LFSR_MAX_W{m}} & taps & ~lfsr_vec_t'(1))) & mask;
         end
         default: begin
            b   = 1'b0;
            nxt = state;
         end
      endcase
      return {b, nxt};
   endfunction

endpackage

// File: rtl/lfsr_step_core.sv
// Combinational single LFSR step, Fibonacci or Galois.
// Unaffected by LFSR_LOCKUP_RECOVER_EN.
module lfsr_step_core
   import lfsr_pkg::*;
#(
   parameter int unsigned WIDTH = 16
)(
   input  logic [WIDTH-1:0] state_i,
   input  logic [WIDTH-1:0] taps_i,
   input  lfsr_mode_e       mode_i,
   output logic [WIDTH-1:0] next_o,
   output logic             bit_o
);

   logic [LFSR_MAX_W:0] res;
   logic                unused_res;

   always_comb begin
      res = lfsr_next(lfsr_vec_t'(state_i), lfsr_vec_t'(taps_i),
                      mode_i, WIDTH);
   end

   assign next_o     = res[WIDTH-1:0];
   assign bit_o      = res[LFSR_MAX_W];
   assign unused_res = ^res;

endmodule

// File: rtl/lfsr_gen.sv
// LFSR generator packing emitted bits into OUT_W-bit stream words.
// Define LFSR_LOCKUP_RECOVER_EN to reload the seed on all-zero lock-up.
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH    = 16,
   parameter int unsigned      OUT_W    = 8,
   parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(1)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reinit,
   input  logic [WIDTH-1:0] seed,
   input  logic [WIDTH-1:0] taps,
   input  logic             mode,
   input  logic             gen_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_bit,
   output logic [WIDTH-1:0] out_state,
   output logic             lockup
);

   localparam int unsigned CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_W - 1);

   logic [WIDTH-1:0] state_q, state_d;
   logic [OUT_W-1:0] coll_q, coll_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             vld_q, vld_d;
   logic             bit_q, bit_d;
   logic             lock_q, lock_d;

   logic [WIDTH-1:0] step_next;
   logic             step_bit;
   logic             stall;
   logic             step;
   logic [OUT_W-1:0] word;

   lfsr_step_core #(.WIDTH(WIDTH)) u_core (
      .state_i (state_q),
      .taps_i  (taps),
      .mode_i  (lfsr_mode_e'(mode)),
      .next_o  (step_next),
      .bit_o   (step_bit)
   );

   always_comb begin
      stall = (cnt_q == LAST) & vld_q & ~out_ready;
      step  = gen_en & ~reinit & ~stall;
      word  = coll_q;
      word[cnt_q] = step_bit;

      state_d = state_q;
      coll_d  = coll_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      bit_d   = bit_q;
      vld_d   = vld_q & ~out_ready;

      if (reinit) begin
         state_d = seed;
         coll_d  = '0;
         cnt_d   = '0;
         vld_d   = 1'b0;
         bit_d   = 1'b0;
      end else begin
         if (step) begin
            state_d = step_next;
            bit_d   = step_bit;
            // Last bit completes the word; handoff at this edge is bubble-free.
            if (cnt_q == LAST) begin
               data_d = word;
               vld_d  = 1'b1;
               cnt_d  = '0;
               coll_d = '0;
            end else begin
               coll_d = word;
               cnt_d  = cnt_q + CNT_W'(1);
            end
         end
`ifdef LFSR_LOCKUP_RECOVER_EN
         if (lock_q) begin
            state_d = (seed == '0) ? WIDTH'(1) : seed;
         end
`endif
      end

      lock_d = (state_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RST_SEED;
         coll_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         vld_q   <= 1'b0;
         bit_q   <= 1'b0;
         lock_q  <= (RST_SEED == '0);
      end else begin
         state_q <= state_d;
         coll_q  <= coll_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         bit_q   <= bit_d;
         lock_q  <= lock_d;
      end
   end

   assign out_valid = vld_q;
   assign out_data  = data_q;
   assign out_bit   = bit_q;
   assign out_state = state_q;
   assign lockup    = lock_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen with WIDTH=5, OUT_W=4, taps x^5+x^2+1.
// Lock-up expectations follow LFSR_LOCKUP_RECOVER_EN.
module tb_lfsr_gen;

   logic       clk;
   logic       rst_n;
   logic       reinit;
   logic [4:0] seed;
   logic [4:0] taps;
   logic       mode;
   logic       gen_en;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_bit;
   logic [4:0] out_state;
   logic       lockup;

   int total = 0;
   int bad   = 0;

   lfsr_gen #(.WIDTH(5), .OUT_W(4), .RST_SEED(5'd1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .reinit    (reinit),
      .seed      (seed),
      .taps      (taps),
      .mode      (mode),
      .gen_en    (gen_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_bit   (out_bit),
      .out_state (out_state),
      .lockup    (lockup)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; reinit = 1'b0; seed = 5'd1; taps = 5'b10100;
      mode = 1'b0; gen_en = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", out_state, 5'd1);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 4'h0);
      chk("rst_bit", out_bit, 1'b0);
      chk("rst_lock", lockup, 1'b0);
      rst_n = 1'b1;

      // test 1: first Fibonacci steps
      reinit = 1'b1;
      tick();
      reinit = 1'b0; gen_en = 1'b1;
      tick();
      chk("fib_s1", out_state, 5'b00010);
      chk("fib_b1", out_bit, 1'b0);
      tick();
      chk("fib_s2", out_state, 5'b00100);
      chk("fib_b2", out_bit, 1'b0);
      tick();
      chk("fib_s3", out_state, 5'b01001);
      chk("fib_b3", out_bit, 1'b1);
      chk("fib_v3", out_valid, 1'b0);

      // test 3: first word, then stall with out_ready low
      tick();
      chk("w1_valid", out_valid, 1'b1);
      chk("w1_data", out_data, 4'h4);
      chk("s4_state", out_state, 5'b10010);
      repeat (3) tick();
      chk("s7_state", out_state, 5'b10110);
      repeat (5) tick();
      chk("stall_state", out_state, 5'b10110);
      chk("stall_data", out_data, 4'h4);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_lock", lockup, 1'b0);

      // test 4: back-to-back words, handoff without bubble
      out_ready = 1'b1;
      tick();
      chk("w2_valid", out_valid, 1'b1);
      chk("w2_data", out_data, 4'h3);
      repeat (3) begin
         tick();
         chk("gap_valid", out_valid, 1'b0);
      end
      tick();
      chk("w3_valid", out_valid, 1'b1);
      chk("w3_data", out_data, 4'hF);
      repeat (4) tick();
      chk("w4_data", out_data, 4'h1);
      repeat (4) tick();
      chk("w5_data", out_data, 4'hB);
      repeat (4) tick();
      chk("w6_data", out_data, 4'hB);
      repeat (4) tick();
      chk("w7_valid", out_valid, 1'b1);
      chk("w7_data", out_data, 4'h2);

      // test 2: period 31
      out_ready = 1'b0;
      repeat (3) tick();
      chk("period_state", out_state, 5'd1);
      chk("period_lock", lockup, 1'b0);

      // test 5: reinit mid-word while a word is pending
      out_ready = 1'b1;
      tick();
      chk("w8_data", out_data, 4'h4);
      out_ready = 1'b0;
      repeat (2) tick();
      chk("pend_valid", out_valid, 1'b1);
      reinit = 1'b1;
      tick();
      reinit = 1'b0;
      chk("ri_valid", out_valid, 1'b0);
      chk("ri_state", out_state, 5'd1);
      chk("ri_bit", out_bit, 1'b0);
      out_ready = 1'b1;
      repeat (3) tick();
      chk("ri_v3", out_valid, 1'b0);
      tick();
      chk("ri_wvalid", out_valid, 1'b1);
      chk("ri_wdata", out_data, 4'h4);

      // asynchronous reset mid-word
      out_ready = 1'b0;
      repeat (2) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 1'b0);
      chk("arst_data", out_data, 4'h0);
      chk("arst_state", out_state, 5'd1);
      gen_en = 1'b0;
      tick();
      rst_n = 1'b1;
      gen_en = 1'b1; out_ready = 1'b1;
      repeat (3) tick();
      chk("arst_v3", out_valid, 1'b0);
      tick();
      chk("arst_wdata", out_data, 4'h4);

      // Galois mode
      gen_en = 1'b0; mode = 1'b1; reinit = 1'b1;
      tick();
      reinit = 1'b0; gen_en = 1'b1;
      repeat (4) tick();
      chk("gal_s4", out_state, 5'b10000);
      chk("gal_b4", out_bit, 1'b0);
      tick();
      chk("gal_s5", out_state, 5'b10101);
      chk("gal_b5", out_bit, 1'b1);
      tick();
      chk("gal_s6", out_state, 5'b11111);

      // test 6: all-zero seed
      gen_en = 1'b0; mode = 1'b0; seed = 5'd0; reinit = 1'b1;
      tick();
      reinit = 1'b0;
      chk("lk_state", out_state, 5'd0);
      chk("lk_flag", lockup, 1'b1);
      tick();
`ifdef LFSR_LOCKUP_RECOVER_EN
      chk("rec_state", out_state, 5'd1);
      chk("rec_flag", lockup, 1'b0);
`else
      chk("hold_state", out_state, 5'd0);
      chk("hold_flag", lockup, 1'b1);
      gen_en = 1'b1;
      tick();
      chk("hold_state2", out_state, 5'd0);
      chk("hold_flag2", lockup, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
